// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and limits for the serial-in/parallel-out block.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // Legal word-length range for the deserializer.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Output holding register occupancy.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_hold_reg
// Description : Output holding register with valid/ready handshake and a
//               sticky overrun flag for words that arrive while it is full.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_hold_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clear_ovr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    hold_state_t      r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;
    logic             w_ovr_event;

    // A completed word is lost only when the register is full and not drained
    // on the same edge.
    assign w_ovr_event = i_load && (r_state == FULL) && !i_ready;

    // Occupancy state, held word and sticky overrun; overrun set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= EMPTY;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_load) begin
                        r_data  <= i_word;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (i_load && i_ready) begin
                        r_data  <= i_word;
                    end else if (i_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase

            if (w_ovr_event) begin
                r_overrun <= 1'b1;
            end else if (i_clear_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = (r_state == FULL);
    assign o_overrun = r_overrun;

endmodule : sipo_hold_reg
`default_nettype wire

// File: rtl/serial_in_parallel_out.sv
`default_nettype none
// ============================================================================
// Module      : serial_in_parallel_out
// Description : Serial-to-parallel deserializer with start-of-frame resync,
//               selectable bit order and a handshaked output register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             out_ready,
    input  logic             clear_ovr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    // Reject word lengths outside the supported range at elaboration.
    generate
        if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
            $error("serial_in_parallel_out: WIDTH out of range");
        end
    endgenerate

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    w_count_eff;
    logic [CW-1:0]    w_idx;
    logic [WIDTH-1:0] w_next_word;
    logic             w_complete;

    // sof restarts the word: the current bit becomes bit 0 of a clean word.
    always_comb begin
        w_count_eff = sof ? '0 : r_count;
        w_idx       = LSB_FIRST ? w_count_eff : (C_LAST - w_count_eff);
        w_next_word = sof ? '0 : r_shift;
        w_next_word[w_idx] = serial_in;
        w_complete  = bit_valid && (w_count_eff == C_LAST);
    end

    // Shifter and bit counter advance only on qualified bits; wrap on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (bit_valid) begin
            if (w_complete) begin
                r_count <= '0;
                r_shift <= '0;
            end else begin
                r_count <= w_count_eff + 1'b1;
                r_shift <= w_next_word;
            end
        end
    end

    assign busy = (r_count != '0);

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_complete),
        .i_word      (w_next_word),
        .i_ready     (out_ready),
        .i_clear_ovr (clear_ovr),
        .o_data      (parallel_out),
        .o_valid     (out_valid),
        .o_overrun   (overrun)
    );

endmodule : serial_in_parallel_out
`default_nettype wire

// File: tb/tb_serial_in_parallel_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_in_parallel_out
// Description : Self-checking bench; LSB-first and MSB-first instances share
//               stimulus and are compared against a bit-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_in_parallel_out;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset, serial_in, bit_valid, sof, out_ready, clear_ovr;
    logic [W-1:0] po_l, po_m;
    logic ov_l, ov_m, bz_l, bz_m, or_l, or_m;

    always #5 clk = ~clk;

    serial_in_parallel_out #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .sof(sof), .out_ready(out_ready), .clear_ovr(clear_ovr),
        .parallel_out(po_l), .out_valid(ov_l), .busy(bz_l), .overrun(or_l)
    );

    serial_in_parallel_out #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .sof(sof), .out_ready(out_ready), .clear_ovr(clear_ovr),
        .parallel_out(po_m), .out_valid(ov_m), .busy(bz_m), .overrun(or_m)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits of the frame in arrival order plus per-instance
    // holding register contents (index 0 = LSB-first, 1 = MSB-first).
    logic         m_bits[$];
    logic [W-1:0] m_data[2];
    logic         m_valid[2];
    logic         m_ovr[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        for (int k = 0; k < 2; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_ovr[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input logic sin, input logic bv, input logic sf,
                              input logic rdy, input logic clr);
        logic         done;
        logic         ev;
        logic [W-1:0] wd[2];
        done  = 1'b0;
        wd[0] = '0;
        wd[1] = '0;
        if (bv) begin
            if (sf) m_bits.delete();
            m_bits.push_back(sin);
            if (m_bits.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    wd[0][i]       = m_bits[i];
                    wd[1][W-1-i]   = m_bits[i];
                end
                m_bits.delete();
            end
        end
        for (int k = 0; k < 2; k++) begin
            ev = done && m_valid[k] && !rdy;
            if (done && (!m_valid[k] || rdy)) begin
                m_data[k]  = wd[k];
                m_valid[k] = 1'b1;
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 1'b0;
            end
            if (ev)       m_ovr[k] = 1'b1;
            else if (clr) m_ovr[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic mb;
        mb = (m_bits.size() != 0);
        check_eq("lsb_data",    32'(po_l), 32'(m_data[0]));
        check_eq("lsb_valid",   32'(ov_l), 32'(m_valid[0]));
        check_eq("lsb_busy",    32'(bz_l), 32'(mb));
        check_eq("lsb_overrun", 32'(or_l), 32'(m_ovr[0]));
        check_eq("msb_data",    32'(po_m), 32'(m_data[1]));
        check_eq("msb_valid",   32'(ov_m), 32'(m_valid[1]));
        check_eq("msb_busy",    32'(bz_m), 32'(mb));
        check_eq("msb_overrun", 32'(or_m), 32'(m_ovr[1]));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic cycle(input logic sin, input logic bv, input logic sf,
                         input logic rdy, input logic clr);
        serial_in = sin;
        bit_valid = bv;
        sof       = sf;
        out_ready = rdy;
        clear_ovr = clr;
        @(posedge clk);
        model_edge(sin, bv, sf, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        bit_valid = 1'b0;
        sof       = 1'b0;
        clear_ovr = 1'b0;
        reset     = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    // Send one word LSB-first in time; ready on the last bit can differ.
    task automatic send_word(input logic [W-1:0] v, input logic sf_first,
                             input logic rdy_last, input logic rdy_other);
        for (int i = 0; i < W; i++) begin
            cycle(v[i], 1'b1, (i == 0) && sf_first,
                  (i == W - 1) ? rdy_last : rdy_other, 1'b0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b0;
        bit_valid = 1'b0;
        sof       = 1'b0;
        out_ready = 1'b0;
        clear_ovr = 1'b0;
        model_reset();
        #12;
        do_reset();
        check_eq("reset_data", 32'(po_l), 32'h0);
        check_eq("reset_valid", 32'(ov_l), 32'h0);

        // Bits 0,0,1,0,0,1,0,0: symmetric pattern, both orders give 0x24.
        send_word(8'h24, 1'b0, 1'b1, 1'b1);
        check_eq("basic_lsb", 32'(po_l), 32'h24);
        check_eq("basic_msb", 32'(po_m), 32'h24);
        check_eq("basic_valid", 32'(ov_l), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("basic_pulse_end", 32'(ov_l), 32'h0);

        // Bits 0,1,0,0,1,0,0,0: 0x12 LSB-first, 0x48 MSB-first.
        send_word(8'h12, 1'b0, 1'b1, 1'b1);
        check_eq("order_lsb", 32'(po_l), 32'h12);
        check_eq("order_msb", 32'(po_m), 32'h48);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun with consumer stalled, then clear.
        send_word(8'h12, 1'b0, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b0, 1'b0);
        check_eq("ovr_data_held", 32'(po_l), 32'h12);
        check_eq("ovr_set", 32'(or_l), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_cleared", 32'(or_l), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ovr_drained", 32'(ov_l), 32'h0);

        // Partial word abandoned by sof.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("partial_busy", 32'(bz_l), 32'h1);
        send_word(8'hA5, 1'b1, 1'b1, 1'b1);
        check_eq("sof_word", 32'(po_l), 32'hA5);
        check_eq("sof_idle", 32'(bz_l), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Accept and completion on the same edge.
        send_word(8'h12, 1'b0, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b1, 1'b0);
        check_eq("swap_data", 32'(po_l), 32'h34);
        check_eq("swap_valid", 32'(ov_l), 32'h1);
        check_eq("swap_no_ovr", 32'(or_l), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        check_eq("midrst_data", 32'(po_l), 32'h0);
        check_eq("midrst_busy", 32'(bz_l), 32'h0);
        send_word(8'h0F, 1'b0, 1'b1, 1'b1);
        check_eq("midrst_word", 32'(po_l), 32'h0F);
        check_eq("midrst_word_msb", 32'(po_m), 32'hF0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 19) == 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_in_parallel_out
`default_nettype wire

// File: doc/serial_in_parallel_out.md
SERIAL_IN_PARALLEL_OUT -- requirements
Module: serial_in_parallel_out

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits, legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 serial_in  input  1: serial data bit.
REQ-006 bit_valid  input  1: serial_in is sampled only on edges where bit_valid=1.
REQ-007 sof  input  1: start of frame, qualified by bit_valid; marks the current bit as bit 0 of a new word.
REQ-008 out_ready  input  1: consumer accepts parallel_out when out_valid=1 and out_ready=1.
REQ-009 clear_ovr  input  1: synchronous clear of the overrun flag.
REQ-010 parallel_out  output  WIDTH: assembled word held in the output register.
REQ-011 out_valid  output  1: parallel_out holds an unaccepted word.
REQ-012 busy  output  1: partial word in progress (bit count nonzero).
REQ-013 overrun  output  1: sticky flag; a completed word was dropped.

Function
REQ-014 Shift register and bit counter (0..WIDTH-1) advance only on edges with bit_valid=1.
REQ-015 LSB_FIRST=1: each sampled bit is written at index = bit count. LSB_FIRST=0: each sampled bit is written at index WIDTH-1-count.
REQ-016 bit_valid=1 with sof=1: the partial word is discarded, and the bit is stored as bit 0 of the new word with count=1. bit_valid=0 makes sof a don't-care.
REQ-017 Word completes on the edge sampling the WIDTH-th bit; the counter wraps to 0 on that same edge.
REQ-018 On completion with the holding register free, the full word (including the final bit) loads parallel_out on that edge; out_valid=1 from the next cycle. Latency is 0 edges after the final bit.
REQ-019 Holding register state machine has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on accept without completion.
  - FULL stays FULL on accept and completion in the same edge; the new word loads and no overrun is raised.
REQ-020 Completion while FULL with no accept on that edge: the new word is dropped, parallel_out is unchanged, and overrun is set to 1.
REQ-021 overrun stays 1 until clear_ovr=1; an overrun event on the same edge as clear_ovr takes priority (overrun stays 1).
REQ-022 parallel_out stays stable while out_valid=1 and not accepted.
REQ-023 busy=1 whenever the bit count is nonzero.

Reset
REQ-024 reset=1 asynchronously forces: parallel_out=0, out_valid=0, overrun=0, busy=0, bit count=0, shift register=0.
REQ-025 reset asserted mid-word discards the partial word; after release, the next sampled bit is bit 0 regardless of sof.
REQ-026 Outputs are valid from the first rising edge after reset deassertion.

Structure
REQ-027 Shared package sipo_pkg holds the holding-state enum (EMPTY, FULL) and the WIDTH range limits.
REQ-028 One sub-module, sipo_hold_reg: output holding register with valid/ready handshake and overrun generation; the top contains the shifter and counter.

Verification
REQ-029 WIDTH=8, LSB_FIRST=1, out_ready=1; bits 0,0,1,0,0,1,0,0 -> parallel_out=0x24 and a single-cycle out_valid pulse after the 8th bit.
REQ-030 LSB_FIRST=0, same bits -> parallel_out=0x24 bit-reversed = 0x24 excluded; use bits 0,1,0,0,1,0,0,0 -> 0x48 (LSB_FIRST=1 gives 0x12).
REQ-031 out_ready=0; send 0x12 then 0x34 -> parallel_out stays 0x12, overrun=1; clear_ovr pulse -> overrun=0.
REQ-032 Send 3 bits, then sof with bit_valid and 8 bits of 0xA5 -> parallel_out=0xA5; busy=1 during the frame.
REQ-033 Hold out_valid=1 with 0x12, assert out_ready on the edge where 0x34 completes -> parallel_out=0x34, out_valid=1, overrun=0.
REQ-034 Assert reset after 5 bits -> all outputs 0; next 8 bits of 0x0F -> parallel_out=0x0F.
